// File: rtl/puzzle_move_ctrl_if.sv
// Player/display-facing signals of the 8-puzzle move sequencer.
// master drives btn/dir and observes the board; slave is the sequencer.
interface puzzle_move_ctrl_if;
  logic        btn;
  logic [1:0]  dir;
  logic [35:0] board;
  logic [15:0] move_cnt;
  logic        solved;
  logic        busy;
  logic        illegal;

  modport master (
    output btn, dir,
    input  board, move_cnt, solved, busy, illegal
  );

  modport slave (
    input  btn, dir,
    output board, move_cnt, solved, busy, illegal
  );
endinterface

// File: rtl/puzzle_move_ctrl.sv
// 8-puzzle move sequencer: debounced press -> legality check -> blank swap -> BCD count + solved flag; `SHUFFLE_EN adds a post-reset LFSR shuffle.
// Press in cycle T: illegal at T+1, board at T+3, count/solved at T+4; busy T+1..T+3; presses while busy are dropped.
module puzzle_move_ctrl #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned SHUFFLE_MOVES = 32,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  puzzle_move_ctrl_if.slave io
);

  localparam logic [35:0] GOAL_BOARD = 36'h0_8765_4321;
  localparam int unsigned DB_W       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef struct packed {
    logic       legal;
    logic [3:0] target;
  } move_t;

`ifdef SHUFFLE_EN
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SWAP, S_UPDATE, S_SHUFFLE} state_t;
  localparam state_t S_RESET = S_SHUFFLE;
`else
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SWAP, S_UPDATE} state_t;
  localparam state_t S_RESET = S_IDLE;
`endif

  // Target cell of the blank for a direction, and whether it stays on the board.
  function automatic move_t decode_move(input logic [3:0] pos, input logic [1:0] d);
    move_t m;
    m.legal  = 1'b0;
    m.target = pos;
    case (d)
      2'd0: if (pos >= 4'd3) begin
        m.legal  = 1'b1;
        m.target = pos - 4'd3;
      end
      2'd1: if (pos <= 4'd5) begin
        m.legal  = 1'b1;
        m.target = pos + 4'd3;
      end
      2'd2: if (pos != 4'd0 && pos != 4'd3 && pos != 4'd6) begin
        m.legal  = 1'b1;
        m.target = pos - 4'd1;
      end
      default: if (pos != 4'd2 && pos != 4'd5 && pos != 4'd8) begin
        m.legal  = 1'b1;
        m.target = pos + 4'd1;
      end
    endcase
    return m;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = (v != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic            sync1, sync2, db_level, press;
  logic [DB_W-1:0] db_cnt;

  state_t      state, state_nxt;
  logic [1:0]  dir_q;
  logic [3:0]  blank_pos;
  logic [3:0]  cells [9];
  logic [15:0] move_cnt_q;
  logic        solved_q;
  logic        at_goal;
  logic        swap_en;
  logic [3:0]  swap_tgt;
  move_t       cur_move;

  // Level flips only after DB_CYCLES consecutive synchronized samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= io.btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        db_level <= sync2;
        db_cnt   <= '0;
        press    <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign cur_move = decode_move(blank_pos, dir_q);

`ifdef SHUFFLE_EN
  localparam int unsigned SC_W = $clog2(SHUFFLE_MOVES + 1);

  logic [7:0]      lfsr;
  logic            shuf_phase;
  logic [SC_W-1:0] shuf_cnt;
  logic            shuf_done;
  move_t           shuf_move;

  assign shuf_move = decode_move(blank_pos, lfsr[1:0]);
  assign shuf_done = (shuf_cnt == SC_W'(SHUFFLE_MOVES));

  // One attempt on every odd phase; taps x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= LFSR_SEED;
      shuf_phase <= 1'b0;
      shuf_cnt   <= '0;
    end else if (state == S_SHUFFLE && !shuf_done) begin
      shuf_phase <= ~shuf_phase;
      if (shuf_phase) begin
        lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        shuf_cnt <= shuf_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
      dir_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && press) begin
        dir_q <= io.dir;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    swap_en   = 1'b0;
    swap_tgt  = blank_pos;
    case (state)
      S_IDLE:   if (press) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = cur_move.legal ? S_SWAP : S_IDLE;
      S_SWAP: begin
        swap_en   = 1'b1;
        swap_tgt  = cur_move.target;
        state_nxt = S_UPDATE;
      end
      S_UPDATE: state_nxt = S_IDLE;
`ifdef SHUFFLE_EN
      S_SHUFFLE: begin
        if (shuf_done) begin
          state_nxt = S_IDLE;
        end else if (shuf_phase) begin
          swap_en  = shuf_move.legal;
          swap_tgt = shuf_move.target;
        end
      end
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        cells[i] <= 4'((i + 1) % 9);
      end
      blank_pos <= 4'd8;
    end else if (swap_en) begin
      for (int i = 0; i < 9; i++) begin
        if (4'(i) == blank_pos) begin
          cells[i] <= cells[swap_tgt];
        end else if (4'(i) == swap_tgt) begin
          cells[i] <= 4'd0;
        end
      end
      blank_pos <= swap_tgt;
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_board
    assign io.board[4*g +: 4] = cells[g];
  end

  assign at_goal = (io.board == GOAL_BOARD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_cnt_q <= 16'h0000;
      solved_q   <= 1'b1;
    end else if (state == S_UPDATE) begin
      move_cnt_q <= bcd_inc(move_cnt_q);
      solved_q   <= at_goal;
    end
`ifdef SHUFFLE_EN
    else if (state == S_SHUFFLE && shuf_done) begin
      solved_q <= at_goal;
    end
`endif
  end

  assign io.move_cnt = move_cnt_q;
  assign io.solved   = solved_q;
  assign io.busy     = (state != S_IDLE);
  assign io.illegal  = (state == S_CHECK) && !cur_move.legal;

  cfg_ok: assert property (@(posedge clk)
    (LFSR_SEED != 8'h00) && (SHUFFLE_MOVES != 0) && (DB_CYCLES != 0));

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// Bench for puzzle_move_ctrl: a cycle-indexed board/press model is compared every cycle,
// plus literal expectations on hand-worked boards and counts.
module tb_puzzle_move_ctrl;
  localparam int          DB   = 4;
  localparam int          SM   = 32;
  localparam logic [7:0]  SEED = 8'hA5;
  localparam logic [35:0] GOAL = 36'h0_8765_4321;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puzzle_move_ctrl_if bus ();

  puzzle_move_ctrl #(.DB_CYCLES(DB), .SHUFFLE_MOVES(SM), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: board as nine cells, timeline in absolute cycle numbers.
  logic [3:0] mb [9];
  int  m_moves, cyc, busy_start, busy_until, ill_cyc, swap_at, cnt_at, shuf_at, sw_a, sw_b;
  logic m_solved, m_level, m_press;
  bit  raw[$];
  bit  win[$];

  function automatic logic [35:0] model_board();
    logic [35:0] b;
    for (int i = 0; i < 9; i++) b[4*i +: 4] = mb[i];
    return b;
  endfunction

  function automatic int blank_of();
    int p = -1;
    for (int i = 0; i < 9; i++) if (mb[i] == 4'd0) p = i;
    return p;
  endfunction

  task automatic try_move(input int p, input logic [1:0] d, output bit ok, output int t);
    int r = p / 3;
    int c = p % 3;
    case (d)
      2'd0: begin ok = (r > 0); t = p - 3; end
      2'd1: begin ok = (r < 2); t = p + 3; end
      2'd2: begin ok = (c > 0); t = p - 1; end
      default: begin ok = (c < 2); t = p + 1; end
    endcase
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    int s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 4'((i + 1) % 9);
    m_moves = 0; m_solved = 1'b1; m_level = 1'b0; m_press = 1'b0;
    ill_cyc = -1; swap_at = -1; cnt_at = -1;
    raw = '{0, 0};
    win.delete();
`ifdef SHUFFLE_EN
    busy_start = cyc; busy_until = cyc + 2*SM; shuf_at = cyc + 2*SM + 1;
`else
    busy_start = 0; busy_until = -1; shuf_at = 0;
`endif
  endtask

`ifdef SHUFFLE_EN
  task automatic model_shuffle();
    logic [7:0] l = SEED;
    bit ok;
    int p, t;
    for (int k = 0; k < SM; k++) begin
      p = blank_of();
      try_move(p, l[1:0], ok, t);
      if (ok) begin mb[p] = mb[t]; mb[t] = 4'd0; end
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask
`endif

  initial begin
    bit ok, s, all_diff;
    int p, t, n;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk) cyc++;
      if (!rst_n) begin
        model_reset();
      end else begin
        n = cyc;
`ifdef SHUFFLE_EN
        if (n == shuf_at) begin model_shuffle(); m_solved = (model_board() == GOAL); end
`endif
        if (n == swap_at) begin mb[sw_a] = mb[sw_b]; mb[sw_b] = 4'd0; end
        if (n == cnt_at) begin m_moves++; m_solved = (model_board() == GOAL); end
        // press seen in cycle n-1 acts only if the sequencer was idle then
        if (m_press && (n - 1) > busy_until) begin
          p = blank_of();
          try_move(p, bus.dir, ok, t);
          busy_start = n;
          if (ok) begin
            busy_until = n + 2; swap_at = n + 2; cnt_at = n + 3; sw_a = p; sw_b = t;
          end else begin
            busy_until = n; ill_cyc = n;
          end
        end
        raw.push_back(bus.btn);
        s = raw.pop_front();
        win.push_back(s);
        if (win.size() > DB) void'(win.pop_front());
        all_diff = (win.size() == DB);
        foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
        m_press = 1'b0;
        if (all_diff) begin m_level = s; m_press = s; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= shuf_at) begin
        check("board", bus.board, model_board());
        check("solved", 36'(bus.solved), 36'(m_solved));
      end
      check("move_cnt", 36'(bus.move_cnt), 36'(bcd_of(m_moves)));
      check("busy", 36'(bus.busy), 36'(cyc >= busy_start && cyc <= busy_until));
      check("illegal", 36'(bus.illegal), 36'(cyc == ill_cyc));
    end
  end

  task automatic press(input logic [1:0] d, output int busy_n, output int ill_n);
    busy_n = 0; ill_n = 0;
    bus.dir = d; bus.btn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 6) bus.dir = ~d;
      if (i == 10) bus.btn = 1'b0;
      busy_n += int'(bus.busy);
      ill_n  += int'(bus.illegal);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int bn, il;
    bus.btn = 1'b0; bus.dir = 2'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
`ifdef SHUFFLE_EN
    begin
      int nb, seen [9];
      bit perm_ok;
      nb = 0;
      bus.btn = 1'b1;
      for (int i = 0; i < 200 && (i == 0 || bus.busy); i++) begin
        @(negedge clk);
        if (i == 12) bus.btn = 1'b0;
        nb += int'(bus.busy);
      end
      check("shuffle_done", 36'(bus.busy), 36'd0);
      check("shuffle_len", 36'(nb >= 2*SM - 4 && nb <= 2*SM + 4), 36'd1);
      check("shuffle_cnt", 36'(bus.move_cnt), 36'h0);
      foreach (seen[i]) seen[i] = 0;
      perm_ok = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (bus.board[4*i +: 4] > 4'd8) perm_ok = 1'b0;
        else seen[bus.board[4*i +: 4]]++;
      end
      foreach (seen[i]) if (seen[i] != 1) perm_ok = 1'b0;
      check("shuffle_perm", 36'(perm_ok), 36'd1);
      press(2'd0, bn, il);
      press(2'd3, bn, il);
    end
`else
    repeat (20) @(negedge clk);
    check("rst_board", bus.board, GOAL);
    check("rst_cnt", 36'(bus.move_cnt), 36'h0);
    check("rst_solved", 36'(bus.solved), 36'd1);
    check("rst_busy", 36'(bus.busy), 36'd0);

    press(2'd1, bn, il);
    check("down_illegal_pulses", 36'(il), 36'd1);
    check("down_illegal_busy", 36'(bn), 36'd1);
    check("down_illegal_board", bus.board, GOAL);
    check("down_illegal_cnt", 36'(bus.move_cnt), 36'h0);

    press(2'd0, bn, il);
    check("up_busy_len", 36'(bn), 36'd3);
    check("up_board", bus.board, 36'h6_8705_4321);
    check("up_cnt", 36'(bus.move_cnt), 36'h0001);
    check("up_solved", 36'(bus.solved), 36'd0);

    press(2'd1, bn, il);
    check("back_board", bus.board, GOAL);
    check("back_cnt", 36'(bus.move_cnt), 36'h0002);
    check("back_solved", 36'(bus.solved), 36'd1);

    bn = 0;
    for (int k = 0; k < 5; k++) begin
      bus.btn = 1'b1; repeat (2) @(negedge clk);
      bus.btn = 1'b0; repeat (2) @(negedge clk);
      bn += int'(bus.busy);
    end
    repeat (8) @(negedge clk);
    check("bounce_board", bus.board, GOAL);
    check("bounce_cnt", 36'(bus.move_cnt), 36'h0002);

    press(2'd2, bn, il);
    check("left1_board", bus.board, 36'h8_0765_4321);
    press(2'd2, bn, il);
    check("left2_board", bus.board, 36'h8_7065_4321);
    press(2'd0, bn, il);
    check("up_from6_board", bus.board, 36'h8_7465_0321);
    press(2'd2, bn, il);
    check("left_edge_illegal", 36'(il), 36'd1);
    press(2'd3, bn, il);
    check("right_board", bus.board, 36'h8_7460_5321);
    check("five_moves_cnt", 36'(bus.move_cnt), 36'h0006);

    // reset lands in the SWAP cycle of an up move
    bus.dir = 2'd0; bus.btn = 1'b1;
    repeat (8) @(negedge clk);
    check("midmove_busy", 36'(bus.busy), 36'd1);
    #2 rst_n = 1'b0;
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midmove_board", bus.board, GOAL);
    check("midmove_cnt", 36'(bus.move_cnt), 36'h0);
    check("midmove_busy_after", 36'(bus.busy), 36'd0);

    for (int k = 0; k < 5; k++) begin
      press(2'd0, bn, il);
      press(2'd1, bn, il);
    end
    check("ten_moves_cnt", 36'(bus.move_cnt), 36'h0010);
    check("ten_moves_board", bus.board, GOAL);
    check("ten_moves_solved", 36'(bus.solved), 36'd1);

    do_reset();
    check("final_rst_cnt", 36'(bus.move_cnt), 36'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/puzzle_move_ctrl.md
Name: puzzle_move_ctrl

Overview:
- Move sequencer for the 8-puzzle board.
- Debounces the player button, takes a direction code and checks that the move is legal for the current blank position.
- Applies legal moves by swapping the blank with its neighbour in the board register, keeps a 4-digit BCD move count and flags the solved arrangement.
- Sits between the button input and the 7-segment display logic in top.

Parameters:
DB_CYCLES, 4, consecutive stable synchronized samples required to change the debounced button level
SHUFFLE_MOVES, 32, LFSR move attempts made after reset (SHUFFLE_EN builds only)
LFSR_SEED, 8'hA5, reset value of the 8-bit shuffle LFSR; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
btn  in  1  raw push-button, asynchronous to clk
dir  in  2  move direction of the blank: 0 up, 1 down, 2 left, 3 right
board  out  36  cell i at [4i+3:4i], i=0..8 row-major; value 0 = blank, 1..8 = tile
move_cnt  out  16  4-digit BCD count of accepted player moves
solved  out  1  high when the board is in the goal arrangement
busy  out  1  high while a move or the shuffle is in progress
illegal  out  1  one-cycle pulse when a press requests an off-board move

Behaviour:
- Reset values (async): board = goal arrangement; move_cnt = 0; solved = 1; busy = 0; illegal = 0; blank_pos = 8; FSM in IDLE (SHUFFLE in SHUFFLE_EN builds); debounce state cleared; LFSR = LFSR_SEED.
- Goal arrangement: cell i = i+1 for i = 0..7; cell 8 = 0.
- Debounce:
  - btn passes through a 2-FF synchronizer.
  - Debounced level changes only after DB_CYCLES consecutive equal samples.
  - A debounced rising edge produces a one-cycle press pulse in cycle T.
  - Falling edges produce nothing.
- Legality for blank at position p (row r = p/3, column c = p%3):
  - up needs r > 0 (target p-3)
  - down needs r < 2 (target p+3)
  - left needs c > 0 (target p-1)
  - right needs c < 2 (target p+1)
- FSM states: IDLE, CHECK, SWAP, UPDATE, plus SHUFFLE in SHUFFLE_EN builds.
- IDLE:
  - A press in cycle T latches dir and moves to CHECK at T+1.
  - A press while not in IDLE is dropped with no side effects.
- CHECK (T+1), busy = 1:
  - Legal: go to SWAP.
  - Illegal: pulse illegal at T+1, then IDLE; board, move_cnt and solved are unchanged.
- SWAP (T+2):
  - Blank cell takes the tile value from the target cell; target cell becomes 0.
  - blank_pos = target.
  - board is visible updated at the end of T+2.
- UPDATE (T+3):
  - move_cnt increments as BCD (digit 9 rolls to 0 with carry).
  - move_cnt saturates at 16'h9999.
  - solved is re-evaluated from the new board.
  - FSM returns to IDLE; busy falls after T+3.
- Moves are always accepted, including from the solved state.
- solved is a registered compare, updated only in UPDATE or at the end of SHUFFLE.
- Reset asserted mid-move: everything returns to reset values at once; the partial move is discarded.
- dir changing after cycle T has no effect on the move in progress.

Optional Feature:
SHUFFLE_EN
- Defined:
  - After reset release the FSM starts in SHUFFLE with busy = 1 and presses dropped.
  - One attempt every 2 cycles, SHUFFLE_MOVES attempts in total.
  - Each attempt takes dir from LFSR[1:0], then steps the LFSR (taps x^8+x^6+x^5+x^4+1).
  - Illegal attempts are skipped silently; illegal does not pulse.
  - Legal attempts swap as in SWAP; move_cnt is not incremented.
  - At the end: solved is evaluated, then IDLE with busy = 0.
- Undefined: no SHUFFLE state, no LFSR; the board powers up solved and IDLE is entered directly.

Test Plan:
- Reset then idle 20 cycles -> board = 36'h0_8765_4321 (cell 8 = 0), move_cnt = 0, solved = 1, busy = 0.
- btn high 10 cycles with dir = 0 -> cells 8 and 5 swap (cell 5 = 0, cell 8 = 6); move_cnt = 16'h0001; solved = 0; busy high exactly 3 cycles.
- From reset, dir = 1 press -> illegal pulses one cycle; board unchanged; move_cnt = 0.
- Up, then down -> board back to goal, move_cnt = 16'h0002, solved = 1.
- btn bounce of 2-cycle pulses -> no press, board unchanged; a second press issued while busy -> dropped, only one move counted.
- Force move_cnt path with 10 alternating up/down moves -> 16'h0010 (BCD carry); with SHUFFLE_EN -> busy held about 2*SHUFFLE_MOVES cycles after reset, exactly one 0 cell and tiles 1..8 each present once.
